// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID circular queue of {pc, inst} entries with flush and one-entry lookahead
module if_id_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          f_valid,
  output logic                          f_ready,
  input  logic [ADDR_WIDTH-1:0]         f_pc,
  input  logic [INST_WIDTH-1:0]         f_inst,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [ADDR_WIDTH-1:0]         d_pc,
  output logic [ADDR_WIDTH-1:0]         d_pc4,
  output logic [INST_WIDTH-1:0]         d_inst,
  output logic                          d_next_valid,
  output logic [ADDR_WIDTH-1:0]         d_pc_next,
  output logic [INST_WIDTH-1:0]         d_inst_next,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(INST_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_nxt;

  logic push;
  logic pop;
  logic is_empty;
  logic is_full;
  logic has_two;

  // Status flags are pure functions of the registered occupancy.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    has_two  = (count_q >= CW'(2));
    push     = f_valid & ~is_full & ~flush;
    pop      = ~is_empty & d_ready & ~flush;
  end

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Control state with asynchronous clear so reset drops every entry at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= f_pc;
      mem_inst_q[wr_ptr_q] <= f_inst;
    end
  end

  // Head and lookahead read-out, zeroed when the corresponding entry is absent.
  always_comb begin
    rd_ptr_nxt   = rd_ptr_q + PW'(1);
    f_ready      = ~is_full;
    d_valid      = ~is_empty;
    d_next_valid = has_two;
    count        = count_q;
    empty        = is_empty;
    full         = is_full;
    d_pc         = '0;
    d_pc4        = '0;
    d_inst       = '0;
    d_pc_next    = '0;
    d_inst_next  = '0;
    if (!is_empty) begin
      d_pc   = mem_pc_q[rd_ptr_q];
      d_pc4  = mem_pc_q[rd_ptr_q] + INST_BYTES;
      d_inst = mem_inst_q[rd_ptr_q];
    end
    if (has_two) begin
      d_pc_next   = mem_pc_q[rd_ptr_nxt];
      d_inst_next = mem_inst_q[rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue model
module tb_if_id_queue;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          f_valid;
  logic          f_ready;
  logic [AW-1:0] f_pc;
  logic [IW-1:0] f_inst;
  logic          d_valid;
  logic          d_ready;
  logic [AW-1:0] d_pc;
  logic [AW-1:0] d_pc4;
  logic [IW-1:0] d_inst;
  logic          d_next_valid;
  logic [AW-1:0] d_pc_next;
  logic [IW-1:0] d_inst_next;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t mq[$];

  if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .f_pc         (f_pc),
    .f_inst       (f_inst),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_pc         (d_pc),
    .d_pc4        (d_pc4),
    .d_inst       (d_inst),
    .d_next_valid (d_next_valid),
    .d_pc_next    (d_pc_next),
    .d_inst_next  (d_inst_next),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list with capacity DEPTH.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = f_valid && (mq.size() < DEPTH);
      do_pop  = d_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: f_pc, inst: f_inst});
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    int n;
    logic [AW-1:0] e_pc, e_pc4, e_pcn;
    logic [IW-1:0] e_inst, e_instn;
    n = mq.size();
    e_pc = '0; e_pc4 = '0; e_inst = '0; e_pcn = '0; e_instn = '0;
    if (n >= 1) begin
      e_pc   = mq[0].pc;
      e_pc4  = mq[0].pc + 64'd4;
      e_inst = mq[0].inst;
    end
    if (n >= 2) begin
      e_pcn   = mq[1].pc;
      e_instn = mq[1].inst;
    end
    chk("m_count", AW'(count), AW'(n));
    chk("m_empty", AW'(empty), AW'(n == 0));
    chk("m_full", AW'(full), AW'(n == DEPTH));
    chk("m_f_ready", AW'(f_ready), AW'(n != DEPTH));
    chk("m_d_valid", AW'(d_valid), AW'(n != 0));
    chk("m_d_next_valid", AW'(d_next_valid), AW'(n >= 2));
    chk("m_d_pc", d_pc, e_pc);
    chk("m_d_pc4", d_pc4, e_pc4);
    chk("m_d_inst", AW'(d_inst), AW'(e_inst));
    chk("m_d_pc_next", d_pc_next, e_pcn);
    chk("m_d_inst_next", AW'(d_inst_next), AW'(e_instn));
  end

  // Apply inputs for one edge, then return 1ns after that edge with inputs idle.
  task automatic step(input logic fv, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                      input logic dr, input logic fl);
    f_valid = fv; f_pc = pc; f_inst = inst; d_ready = dr; flush = fl;
    @(posedge clk);
    #1;
    f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0; f_pc = '0; f_inst = '0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [IW-1:0] inst);
    step(1'b1, pc, inst, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0; f_pc = '0; f_inst = '0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_count", AW'(count), 64'd0);
    chk("rst_f_ready", AW'(f_ready), 64'd1);
    chk("rst_d_valid", AW'(d_valid), 64'd0);
    chk("rst_empty", AW'(empty), 64'd1);

    // Fill: first push lands on the first edge after reset release.
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(4 * i), 32'hA000_0000 + 32'(i));
    chk("fill_full", AW'(full), 64'd1);
    chk("fill_f_ready", AW'(f_ready), 64'd0);
    chk("fill_d_pc", d_pc, 64'h1000);
    chk("fill_d_pc4", d_pc4, 64'h1004);
    chk("fill_d_pc_next", d_pc_next, 64'h1004);
    push(64'h2000, 32'hBAD0_0000);
    chk("fifth_count", AW'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_d_pc", d_pc, 64'h1000 + 64'(4 * i));
      chk("drain_d_inst", AW'(d_inst), 64'hA000_0000 + 64'(i));
      pop();
    end
    chk("drain_empty", AW'(empty), 64'd1);

    // Streaming across several pointer wraps.
    push(64'h3000, 32'h3000);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 64'h3004 + 64'(4 * k), 32'h3004 + 32'(4 * k), 1'b1, 1'b0);
      chk("stream_count", AW'(count), 64'd1);
      chk("stream_d_pc", d_pc, 64'h3004 + 64'(4 * k));
    end
    pop();

    // Flush beats a concurrent push and pop.
    for (int i = 0; i < 3; i++) push(64'h4000 + 64'(4 * i), 32'h4000 + 32'(i));
    step(1'b1, 64'h5000, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush_count", AW'(count), 64'd0);
    chk("flush_d_valid", AW'(d_valid), 64'd0);
    chk("flush_f_ready", AW'(f_ready), 64'd1);
    push(64'h6000, 32'h1111_1111);
    chk("post_flush_inst", AW'(d_inst), 64'h1111_1111);
    chk("post_flush_count", AW'(count), 64'd1);
    pop();

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 4; i++) push(64'h7000 + 64'(4 * i), 32'h7000 + 32'(i));
    step(1'b1, 64'h7010, 32'h7010, 1'b1, 1'b0);
    chk("fullpop_count", AW'(count), 64'd3);
    chk("fullpop_f_ready", AW'(f_ready), 64'd1);
    chk("fullpop_d_pc", d_pc, 64'h7004);
    push(64'h7010, 32'h7010);
    chk("fullpop_refill", AW'(count), 64'd4);
    for (int i = 0; i < 3; i++) pop();
    chk("fullpop_tail", d_pc, 64'h7010);
    pop();

    // Lookahead gating and pc+4 wrap.
    push(64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678);
    chk("la_pc4_wrap", d_pc4, 64'd0);
    chk("la_next_valid0", AW'(d_next_valid), 64'd0);
    chk("la_inst_next0", AW'(d_inst_next), 64'd0);
    push(64'h0, 32'h9ABC_DEF0);
    chk("la_next_valid1", AW'(d_next_valid), 64'd1);
    chk("la_inst_next1", AW'(d_inst_next), 64'h9ABC_DEF0);

    // Asynchronous reset mid-cycle with three entries queued.
    push(64'h8000, 32'h8000);
    chk("pre_rst_count", AW'(count), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", AW'(count), 64'd0);
    chk("arst_d_valid", AW'(d_valid), 64'd0);
    chk("arst_f_ready", AW'(f_ready), 64'd1);
    chk("arst_d_pc", d_pc, 64'd0);
    chk("arst_d_inst", AW'(d_inst), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(64'h9000, 32'h9000);
    chk("post_rst_push", d_pc, 64'h9000);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
